// File: rtl/jam_cost_table.sv
// jam_cost_table: streaming-loaded 8x8 cost table feeding the job-assignment
// engine. Loads 64 words over a valid/ready handshake, then serves registered
// W/J lookups while the engine runs, and parks until a reload request.
module jam_cost_table #(
  parameter int unsigned COST_W = 7,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned SUM_W  = 13
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  input  logic [COST_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  input  logic [IDX_W-1:0]  W,
  input  logic [IDX_W-1:0]  J,
  output logic [COST_W-1:0] Cost,
  output logic              jam_rst,
  input  logic              jam_valid,
  output logic              table_ready,
  output logic              load_done,
  output logic [SUM_W-1:0]  load_sum
);

  localparam int unsigned ADDR_W = 2 * IDX_W;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr;
  logic [COST_W-1:0] mem [DEPTH];
  logic              xfer;
  logic              last_word;
  logic              run_stay;
  logic              restart;

  // State register; RST forces LOAD from anywhere
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= LOAD;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: LOAD until 64th word, RUN until engine result, DONE until reload
  always_comb begin
    next_state = state;
    case (state)
      LOAD:    if (xfer && last_word) next_state = RUN;
      RUN:     if (jam_valid)         next_state = DONE;
      DONE:    if (reload)            next_state = LOAD;
      default:                        next_state = LOAD;
    endcase
  end

  // Combinational handshake and control decodes
  always_comb begin
    in_ready  = (state == LOAD);
    xfer      = in_valid && (state == LOAD);
    last_word = (addr == ADDR_W'(DEPTH - 1));
    run_stay  = (state == RUN) && (next_state == RUN);
    restart   = (state == DONE) && reload;
  end

  // Table storage; contents survive reset, RST blocks a same-cycle write
  always_ff @(posedge CLK) begin
    if (!RST && xfer) begin
      mem[addr] <= in_data;
    end
  end

  // Load address, checksum and engine-facing registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr        <= '0;
      load_sum    <= '0;
      Cost        <= '0;
      jam_rst     <= 1'b1;
      table_ready <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      load_done <= xfer && last_word;
      if (xfer) begin
        addr     <= addr + ADDR_W'(1);
        load_sum <= load_sum + SUM_W'(in_data);
      end else if (restart) begin
        addr     <= '0;
        load_sum <= '0;
      end
      // Cost and engine reset only valid while RUN continues into next cycle,
      // so the engine sees reset on the first RUN cycle and on leaving RUN
      Cost        <= run_stay ? mem[{W, J}] : '0;
      jam_rst     <= !run_stay;
      table_ready <= (next_state == RUN);
    end
  end

endmodule
